// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared encodings for the MIPS decode/execute slice: opcode and
//            funct constants, ALU op classes, ALU function codes, the decoded
//            control bundle type, and the funct -> ALU function mapping.
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  // R-type funct field, instruction bits [5:0]
  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;
  localparam logic [5:0] c_FN_NOR = 6'b100111;

  // ALU op class produced by the main decoder
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] c_ALUOP_RSVD  = 2'b11;

  // ALU function codes
  localparam logic [3:0] c_ALUCTL_AND = 4'b0000;
  localparam logic [3:0] c_ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] c_ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] c_ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] c_ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] c_ALUCTL_NOR = 4'b1100;

  // Decoded control bundle
  typedef struct packed {
    logic       regdst;
    logic       branch_eq;
    logic       branch_ne;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrc;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  // R-type funct to ALU function code; unlisted functs fall back to AND
  function automatic logic [3:0] funct_to_aluctl(input logic [5:0] funct);
    logic [3:0] v_ctl;
    case (funct)
      c_FN_ADD: v_ctl = c_ALUCTL_ADD;
      c_FN_SUB: v_ctl = c_ALUCTL_SUB;
      c_FN_AND: v_ctl = c_ALUCTL_AND;
      c_FN_OR:  v_ctl = c_ALUCTL_OR;
      c_FN_SLT: v_ctl = c_ALUCTL_SLT;
      c_FN_NOR: v_ctl = c_ALUCTL_NOR;
      default:  v_ctl = c_ALUCTL_AND;
    endcase
    return v_ctl;
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_decode_exec_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Combinational ALU datapath and zero flag. The zero flag is
//            derived from the very result presented on o_result.
// Ports    : i_a      - operand A
//            i_b      - operand B (already muxed between rt data and imm)
//            i_aluctl - ALU function code
//            o_result - ALU result, wraps modulo 2^W
//            o_zero   - high when o_result is all zeros
// Revision : 1.0  initial release
// ============================================================================
module alu_core
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_aluctl,
  output logic [W-1:0] o_result,
  output logic         o_zero
);

  logic         w_lt;
  logic [W-1:0] w_result;

  assign w_lt = $signed(i_a) < $signed(i_b);

  always_comb begin
    w_result = '0;
    case (i_aluctl)
      c_ALUCTL_AND: w_result = i_a & i_b;
      c_ALUCTL_OR:  w_result = i_a | i_b;
      c_ALUCTL_ADD: w_result = i_a + i_b;
      c_ALUCTL_SUB: w_result = i_a - i_b;
      c_ALUCTL_SLT: w_result = {{(W-1){1'b0}}, w_lt};
      c_ALUCTL_NOR: w_result = ~(i_a | i_b);
      default:      w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == '0);

endmodule : alu_core
`default_nettype wire

// File: rtl/mips_decode_exec.sv
`default_nettype none
// ============================================================================
// Module   : mips_decode_exec
// Purpose  : Single-cycle MIPS main decoder, ALU control and ALU, with every
//            output registered (latency 1, one instruction per cycle).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            bubble              - zero the registered control outputs
//            opcode, funct       - instruction fields [31:26] and [5:0]
//            a, b, seimm         - rs data, rt data, sign-extended immediate
//            regdst ... jump     - registered control flags
//            aluop, aluctl       - registered ALU op class / function code
//            result, zero        - registered ALU result and its zero flag
// Revision : 1.0  initial release
// ============================================================================
module mips_decode_exec
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bubble,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] seimm,
  output logic         regdst,
  output logic         branch_eq,
  output logic         branch_ne,
  output logic         memread,
  output logic         memwrite,
  output logic         memtoreg,
  output logic         regwrite,
  output logic         alusrc,
  output logic         jump,
  output logic [1:0]   aluop,
  output logic [3:0]   aluctl,
  output logic [W-1:0] result,
  output logic         zero
);

  ctrl_t        w_ctrl;
  logic         w_known_op;
  logic [3:0]   w_aluctl;
  logic [W-1:0] w_opb;
  logic [W-1:0] w_result;
  logic         w_zero;

  ctrl_t        r_ctrl;
  logic [3:0]   r_aluctl;
  logic [W-1:0] r_result;
  logic         r_zero;

  // Main decoder
  always_comb begin
    w_ctrl     = '0;
    w_known_op = 1'b1;
    case (opcode)
      c_OP_RTYPE: begin
        w_ctrl.regdst   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.aluop    = c_ALUOP_FUNCT;
      end
      c_OP_LW: begin
        w_ctrl.memread  = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.aluop    = c_ALUOP_ADD;
      end
      c_OP_SW: begin
        w_ctrl.memwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.aluop    = c_ALUOP_ADD;
      end
      c_OP_BEQ: begin
        w_ctrl.branch_eq = 1'b1;
        w_ctrl.aluop     = c_ALUOP_SUB;
      end
      c_OP_BNE: begin
        w_ctrl.branch_ne = 1'b1;
        w_ctrl.aluop     = c_ALUOP_SUB;
      end
      c_OP_ADDI: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.aluop    = c_ALUOP_ADD;
      end
      c_OP_J: begin
        w_ctrl.jump  = 1'b1;
        w_ctrl.aluop = c_ALUOP_ADD;
      end
      default: begin
        w_known_op = 1'b0;
      end
    endcase
  end

  // ALU control. Unrecognised opcodes share aluop=00 with loads/stores but
  // must not add: they fall through to AND, so they are split out here.
  always_comb begin
    w_aluctl = c_ALUCTL_AND;
    case (w_ctrl.aluop)
      c_ALUOP_ADD:   w_aluctl = w_known_op ? c_ALUCTL_ADD : c_ALUCTL_AND;
      c_ALUOP_SUB:   w_aluctl = c_ALUCTL_SUB;
      c_ALUOP_FUNCT: w_aluctl = funct_to_aluctl(funct);
      default:       w_aluctl = c_ALUCTL_AND;
    endcase
  end

  assign w_opb = w_ctrl.alusrc ? seimm : b;

  alu_core #(
    .W (W)
  ) u_alu_core (
    .i_a      (a),
    .i_b      (w_opb),
    .i_aluctl (w_aluctl),
    .o_result (w_result),
    .o_zero   (w_zero)
  );

  // Output register. A bubble clears only the control side; the datapath
  // still captures this cycle's ALU output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl   <= '0;
      r_aluctl <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_result <= w_result;
      r_zero   <= w_zero;
      if (bubble) begin
        r_ctrl   <= '0;
        r_aluctl <= '0;
      end else begin
        r_ctrl   <= w_ctrl;
        r_aluctl <= w_aluctl;
      end
    end
  end

  assign regdst    = r_ctrl.regdst;
  assign branch_eq = r_ctrl.branch_eq;
  assign branch_ne = r_ctrl.branch_ne;
  assign memread   = r_ctrl.memread;
  assign memwrite  = r_ctrl.memwrite;
  assign memtoreg  = r_ctrl.memtoreg;
  assign regwrite  = r_ctrl.regwrite;
  assign alusrc    = r_ctrl.alusrc;
  assign jump      = r_ctrl.jump;
  assign aluop     = r_ctrl.aluop;
  assign aluctl    = r_aluctl;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule : mips_decode_exec
`default_nettype wire

// File: tb/tb_mips_decode_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_decode_exec
// Purpose  : Self-checking bench for mips_decode_exec: directed instruction
//            scenarios plus randomized instructions against an
//            instruction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_decode_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         bubble;
  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] seimm;
  logic         regdst, branch_eq, branch_ne, memread, memwrite;
  logic         memtoreg, regwrite, alusrc, jump;
  logic [1:0]   aluop;
  logic [3:0]   aluctl;
  logic [W-1:0] result;
  logic         zero;

  int errors = 0;
  int checks = 0;

  // Control outputs gathered in the order:
  // regdst beq bne memread memwrite memtoreg regwrite alusrc jump aluop aluctl
  logic [14:0] ctl;
  assign ctl = {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
                regwrite, alusrc, jump, aluop, aluctl};

  always #5 clk = ~clk;

  mips_decode_exec #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bubble    (bubble),
    .opcode    (opcode),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .seimm     (seimm),
    .regdst    (regdst),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrc    (alusrc),
    .jump      (jump),
    .aluop     (aluop),
    .aluctl    (aluctl),
    .result    (result),
    .zero      (zero)
  );

  // ---------------- reference model (instruction semantics) ----------------
  function automatic logic [14:0] model_ctl(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] rctl;
    case (fn)
      6'b100000: rctl = 4'b0010;
      6'b100010: rctl = 4'b0110;
      6'b100100: rctl = 4'b0000;
      6'b100101: rctl = 4'b0001;
      6'b101010: rctl = 4'b0111;
      6'b100111: rctl = 4'b1100;
      default:   rctl = 4'b0000;
    endcase
    case (op)
      6'b000000: return {9'b100000100, 2'b10, rctl};
      6'b100011: return {9'b000101110, 2'b00, 4'b0010};
      6'b101011: return {9'b000010010, 2'b00, 4'b0010};
      6'b000100: return {9'b010000000, 2'b01, 4'b0110};
      6'b000101: return {9'b001000000, 2'b01, 4'b0110};
      6'b001000: return {9'b000000110, 2'b00, 4'b0010};
      6'b000010: return {9'b000000001, 2'b00, 4'b0010};
      default:   return 15'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] model_result(input logic [5:0] op, input logic [5:0] fn,
                                                 input logic [W-1:0] ra, input logic [W-1:0] rb,
                                                 input logic [W-1:0] imm);
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: return ra + rb;
          6'b100010: return ra - rb;
          6'b100101: return ra | rb;
          6'b101010: return ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
          6'b100111: return ~(ra | rb);
          default:   return ra & rb;
        endcase
      end
      6'b100011, 6'b101011, 6'b001000: return ra + imm;
      6'b000100, 6'b000101:            return ra - rb;
      6'b000010:                       return ra + rb;
      default:                         return ra & rb;
    endcase
  endfunction

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input logic [W-1:0] imm);
    opcode = op; funct = fn; a = ra; b = rb; seimm = imm;
  endtask

  // ---------------------------------- tests ---------------------------------
  task automatic test_reset();
    rst = 1'b1; bubble = 1'b0;
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
    step(); step();
    checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL reset_ctl: got %h want %h", ctl, 15'd0); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero); end
    rst = 1'b0;
  endtask

  task automatic test_rtype_add();
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'hDEAD_0000);
    step();
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL radd_result: got %h want %h", result, 32'd12); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL radd_zero: got %b want 0", zero); end
    checks++; if (ctl !== {9'b100000100, 2'b10, 4'b0010}) begin
      errors++; $display("FAIL radd_ctl: got %b want %b", ctl, {9'b100000100, 2'b10, 4'b0010}); end
  endtask

  task automatic test_beq();
    drive(6'b000100, 6'b000000, 32'h1234, 32'h1234, 32'h0000_0040);
    step();
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL beq_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL beq_zero: got %b want 1", zero); end
    checks++; if (ctl !== {9'b010000000, 2'b01, 4'b0110}) begin
      errors++; $display("FAIL beq_ctl: got %b want %b", ctl, {9'b010000000, 2'b01, 4'b0110}); end
  endtask

  task automatic test_lw();
    drive(6'b100011, 6'b000000, 32'h100, 32'h5555_5555, 32'hFFFF_FFFC);
    step();
    checks++; if (result !== 32'hFC) begin errors++; $display("FAIL lw_result: got %h want %h", result, 32'hFC); end
    checks++; if (ctl !== {9'b000101110, 2'b00, 4'b0010}) begin
      errors++; $display("FAIL lw_ctl: got %b want %b", ctl, {9'b000101110, 2'b00, 4'b0010}); end
  endtask

  task automatic test_slt();
    drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    step();
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL slt_neg_result: got %h want 1", result); end
    drive(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0);
    step();
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL slt_swap_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL slt_swap_zero: got %b want 1", zero); end
  endtask

  task automatic test_bubble();
    bubble = 1'b1;
    drive(6'b101011, 6'b000000, 32'h200, 32'h77, 32'h10);
    step();
    checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL bubble_ctl: got %b want 0", ctl); end
    checks++; if (result !== 32'h210) begin errors++; $display("FAIL bubble_result: got %h want %h", result, 32'h210); end
    bubble = 1'b0;
    step();
    checks++; if (ctl !== {9'b000010010, 2'b00, 4'b0010}) begin
      errors++; $display("FAIL sw_ctl: got %b want %b", ctl, {9'b000010010, 2'b00, 4'b0010}); end
  endtask

  task automatic test_reset_midstream();
    drive(6'b001000, 6'b000000, 32'h40, 32'h0, 32'h2);
    step();
    rst = 1'b1; bubble = 1'b1;
    drive(6'b000000, 6'b100000, 32'd9, 32'd9, 32'd0);
    step();
    checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL midrst_ctl: got %b want 0", ctl); end
    checks++; if (result !== '0 || zero !== 1'b0) begin
      errors++; $display("FAIL midrst_data: got result=%h zero=%b want 0/0", result, zero); end
    rst = 1'b0; bubble = 1'b0;
    step();
    checks++; if (result !== 32'd18) begin errors++; $display("FAIL postrst_result: got %h want %h", result, 32'd18); end
    checks++; if (ctl !== {9'b100000100, 2'b10, 4'b0010}) begin
      errors++; $display("FAIL postrst_ctl: got %b want %b", ctl, {9'b100000100, 2'b10, 4'b0010}); end
  endtask

  task automatic test_unknown_opcode();
    drive(6'b111111, 6'b100000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFFF_FFFF);
    step();
    checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL unk_ctl: got %b want 0", ctl); end
    checks++; if (result !== 32'h00F0_1200) begin
      errors++; $display("FAIL unk_result: got %h want %h", result, 32'h00F0_1200); end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] fns [7];
    logic [5:0] op, fn;
    logic [W-1:0] ra, rb, imm, er;
    logic [14:0] ec;
    logic bub;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
    for (int i = 0; i < 400; i++) begin
      op  = ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 7)] : 6'($urandom);
      fn  = ($urandom_range(0, 9) < 9) ? fns[$urandom_range(0, 5)] : 6'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      bub = ($urandom_range(0, 4) == 0);
      bubble = bub;
      drive(op, fn, ra, rb, imm);
      ec = bub ? 15'd0 : model_ctl(op, fn);
      er = model_result(op, fn, ra, rb, imm);
      step();
      checks++; if (ctl !== ec) begin
        errors++; $display("FAIL rand_ctl[%0d] op=%b fn=%b: got %b want %b", i, op, fn, ctl, ec); end
      checks++; if (result !== er || zero !== (er == 0)) begin
        errors++; $display("FAIL rand_data[%0d] op=%b fn=%b: got %h/%b want %h/%b",
                           i, op, fn, result, zero, er, (er == 0)); end
    end
    bubble = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bubble = 1'b0;
    drive(6'd0, 6'd0, '0, '0, '0);
    #1;
    test_reset();
    test_rtype_add();
    test_beq();
    test_lw();
    test_slt();
    test_bubble();
    test_reset_midstream();
    test_unknown_opcode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mips_decode_exec
`default_nettype wire

// File: doc/mips_decode_exec.md
MIPS_DECODE_EXEC -- requirements
Module: mips_decode_exec

Interface
REQ-001 SHALL have parameter: W, 32, datapath width in bits.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: bubble  in  1  when high, registered control outputs load 0 (stall/flush insertion).
REQ-005 SHALL have port: opcode  in  6  instruction bits [31:26].
REQ-006 SHALL have port: funct  in  6  instruction bits [5:0].
REQ-007 SHALL have port: a  in  W  ALU operand A (rs data).
REQ-008 SHALL have port: b  in  W  register operand B (rt data).
REQ-009 SHALL have port: seimm  in  W  sign-extended immediate.
REQ-010 SHALL have port: regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump  out  1 each  registered control flags.
REQ-011 SHALL have port: aluop  out  2  registered ALU op class.
REQ-012 SHALL have port: aluctl  out  4  registered ALU function code.
REQ-013 SHALL have port: result  out  W  registered ALU result.
REQ-014 SHALL have port: zero  out  1  registered, high when result equals 0.

Function
REQ-015 SHALL decode opcode combinationally: 000000 R-type (regdst, regwrite, aluop=10); 100011 lw (memread, memtoreg, regwrite, alusrc, aluop=00); 101011 sw (memwrite, alusrc, aluop=00); 000100 beq (branch_eq, aluop=01); 000101 bne (branch_ne, aluop=01); 001000 addi (regwrite, alusrc, aluop=00); 000010 j (jump, all others 0).
REQ-016 SHALL drive every control flag and aluop to 0 for any other opcode.
REQ-017 SHALL map aluop to aluctl: 00 -> 0010 (add), 01 -> 0110 (sub), 10 -> by funct, 11 -> 0000.
REQ-018 SHALL map funct for aluop=10: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100, any other -> 0000.
REQ-019 SHALL select ALU operand B = seimm when decoded alusrc=1, else b.
REQ-020 SHALL compute per aluctl: 0000 a AND B; 0001 a OR B; 0010 a+B modulo 2^W; 0110 a-B modulo 2^W; 0111 1 if signed(a)<signed(B) else 0; 1100 NOR(a,B); any other code -> 0.
REQ-021 SHALL ignore overflow/carry; no exception output.
REQ-022 SHALL present all outputs exactly 1 cycle after inputs are sampled (latency 1, throughput 1/cycle).
REQ-023 SHALL, when bubble=1 at an edge, load 0 into all control flags, aluop and aluctl, while result and zero still register the computed values.
REQ-024 SHALL compute zero from the same ALU result that is registered (not from the previous result).

Reset
REQ-025 SHALL, when rst=1 at a rising edge, clear every output to 0 (zero output also 0); rst overrides bubble.
REQ-026 SHALL resume normal registration on the first edge with rst=0; no reset recovery cycles.

Structure
REQ-027 SHALL place opcode constants, funct constants, aluop encodings and aluctl encodings in shared package mips_pkg.
REQ-028 SHALL implement the ALU datapath (REQ-020 and the zero flag) as one sub-module named alu_core; decode and aluctl mapping stay in the top module.

Verification
REQ-029 SHALL cover R-type add: opcode=000000, funct=100000, a=5, b=7 -> next cycle result=12, zero=0, regdst=1, regwrite=1, aluctl=0010.
REQ-030 SHALL cover beq equality: opcode=000100, a=b=0x1234 -> result=0, zero=1, branch_eq=1, aluop=01, aluctl=0110.
REQ-031 SHALL cover lw address: opcode=100011, a=0x100, seimm=0xFFFFFFFC -> result=0xFC, memread=1, memtoreg=1, alusrc=1, regwrite=1.
REQ-032 SHALL cover signed slt: funct=101010, a=0xFFFFFFFF, b=1 -> result=1; swapped operands -> result=0.
REQ-033 SHALL cover bubble and reset: bubble=1 with sw inputs -> all control outputs 0; rst=1 mid-stream -> all outputs 0 next edge.
REQ-034 SHALL cover an unknown opcode such as 111111 -> all control flags and aluop 0, aluctl=0000, result = a AND b.
